// File: rtl/mux2_stream_arb_pkg.sv
// Shared definitions for the two-input packet stream arbiter:
// FSM state encodings and the default payload width.
package mux2_stream_arb_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK1 = 2'b01,
        LOCK2 = 2'b10
    } state_t;

endpackage

// File: rtl/mux_out_reg.sv
// Single-entry output register with valid/ready hold: a loaded beat is held
// stable until the downstream accepts it.
module mux_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_can_load
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    // A new beat may enter when the register is empty or is being drained this cycle.
    assign o_can_load = !r_valid || i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/mux2_stream_arb.sv
// Two-channel packet arbiter: locks onto one input for a whole packet and
// alternates priority between channels after each packet.
module mux2_stream_arb
    import mux2_stream_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic [DATA_W-1:0] I_in1_data,
    input  logic              I_in1_valid,
    input  logic              I_in1_last,
    output logic              O_in1_ready,
    input  logic [DATA_W-1:0] I_in2_data,
    input  logic              I_in2_valid,
    input  logic              I_in2_last,
    output logic              O_in2_ready,
    output logic [DATA_W-1:0] O_out_data,
    output logic              O_out_valid,
    output logic              O_out_last,
    input  logic              I_out_ready,
    output logic              O_sel,
    output logic              O_busy
);

    state_t            r_state;
    logic              r_prio;
    logic              r_sel;
    logic              w_can_load;
    logic              w_acc1;
    logic              w_acc2;
    logic              w_load;
    logic [DATA_W-1:0] w_data;
    logic              w_last;

    assign O_in1_ready = (r_state == LOCK1) && w_can_load;
    assign O_in2_ready = (r_state == LOCK2) && w_can_load;

    assign w_acc1 = O_in1_ready && I_in1_valid;
    assign w_acc2 = O_in2_ready && I_in2_valid;
    assign w_load = w_acc1 || w_acc2;
    assign w_data = (r_state == LOCK1) ? I_in1_data : I_in2_data;
    assign w_last = (r_state == LOCK1) ? I_in1_last : I_in2_last;

    // r_prio = 1 means channel 1 wins a tie; it flips to the other channel
    // whenever a packet completes, giving round-robin under contention.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= IDLE;
            r_prio  <= 1'b1;
            r_sel   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (I_in1_valid && (!I_in2_valid || r_prio)) begin
                        r_state <= LOCK1;
                        r_sel   <= 1'b1;
                    end else if (I_in2_valid) begin
                        r_state <= LOCK2;
                        r_sel   <= 1'b0;
                    end
                end
                LOCK1: begin
                    if (w_acc1 && I_in1_last) begin
                        r_state <= IDLE;
                        r_prio  <= 1'b0;
                    end
                end
                LOCK2: begin
                    if (w_acc2 && I_in2_last) begin
                        r_state <= IDLE;
                        r_prio  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign O_sel  = r_sel;
    assign O_busy = (r_state != IDLE);

    mux_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .i_clk      (I_clk),
        .i_rst_n    (I_rst_n),
        .i_load     (w_load),
        .i_data     (w_data),
        .i_last     (w_last),
        .i_ready    (I_out_ready),
        .o_valid    (O_out_valid),
        .o_data     (O_out_data),
        .o_last     (O_out_last),
        .o_can_load (w_can_load)
    );

endmodule

// File: tb/tb_mux2_stream_arb.sv
// Scoreboard bench for mux2_stream_arb: accepted input beats are queued and
// matched against output beats, with per-scenario checks of grant/ready/busy.
module tb_mux2_stream_arb;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       I_clk = 1'b0;
    logic       I_rst_n = 1'b0;
    logic [7:0] I_in1_data = '0;
    logic       I_in1_valid = 1'b0;
    logic       I_in1_last = 1'b0;
    logic       O_in1_ready;
    logic [7:0] I_in2_data = '0;
    logic       I_in2_valid = 1'b0;
    logic       I_in2_last = 1'b0;
    logic       O_in2_ready;
    logic [7:0] O_out_data;
    logic       O_out_valid;
    logic       O_out_last;
    logic       I_out_ready = 1'b1;
    logic       O_sel;
    logic       O_busy;

    int    checkCount = 0;
    int    passCount = 0;
    int    cyc = 0;
    beat_t sbq[$];
    int    pktStarts[$];
    bit    inPkt = 0;
    bit    gapCheck = 0;
    int    prevLastCyc = -1;

    mux2_stream_arb #(.DATA_W(8)) dut (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_in1_data  (I_in1_data),
        .I_in1_valid (I_in1_valid),
        .I_in1_last  (I_in1_last),
        .O_in1_ready (O_in1_ready),
        .I_in2_data  (I_in2_data),
        .I_in2_valid (I_in2_valid),
        .I_in2_last  (I_in2_last),
        .O_in2_ready (O_in2_ready),
        .O_out_data  (O_out_data),
        .O_out_valid (O_out_valid),
        .O_out_last  (O_out_last),
        .I_out_ready (I_out_ready),
        .O_sel       (O_sel),
        .O_busy      (O_busy)
    );

    always #5 I_clk = ~I_clk;
    always @(posedge I_clk) cyc <= cyc + 1;

    // Output side of the scoreboard: every transferred beat must match the oldest accepted one.
    always @(negedge I_clk) begin
        if (O_out_valid && I_out_ready) begin
            checkCount++;
            if (sbq.size() == 0) begin
                $display("[TB] FAIL out_unexpected: got data=%h last=%b, required no beat", O_out_data, O_out_last);
            end else begin
                beat_t e;
                e = sbq.pop_front();
                if ({O_out_data, O_out_last, O_sel} !== {e.data, e.last, (e.ch == 1)})
                    $display("[TB] FAIL out_beat: got data=%h last=%b sel=%b, required data=%h last=%b sel=%b",
                             O_out_data, O_out_last, O_sel, e.data, e.last, (e.ch == 1));
                else
                    passCount++;
                if (!inPkt) begin
                    pktStarts.push_back(e.ch);
                    if (gapCheck && prevLastCyc >= 0) begin
                        checkCount++;
                        if (cyc - prevLastCyc !== 2)
                            $display("[TB] FAIL packet_gap: got %0d cycles, required 2", cyc - prevLastCyc);
                        else
                            passCount++;
                    end
                end
                inPkt = !e.last;
                if (e.last) prevLastCyc = cyc;
            end
        end
    end

    task automatic driveChannel(input int ch, input int npk, input int nb, input logic [7:0] base);
        for (int p = 0; p < npk; p++) begin
            for (int b = 0; b < nb; b++) begin
                logic [7:0] d;
                logic       l;
                bit         got;
                d = base + 8'(p * 16 + b);
                l = (b == nb - 1);
                if (ch == 1) begin
                    I_in1_data = d; I_in1_valid = 1'b1; I_in1_last = l;
                end else begin
                    I_in2_data = d; I_in2_valid = 1'b1; I_in2_last = l;
                end
                got = 0;
                for (int t = 0; t < 200 && !got; t++) begin
                    @(negedge I_clk);
                    if (ch == 1) got = O_in1_ready && I_in1_valid;
                    else         got = O_in2_ready && I_in2_valid;
                end
                if (!got) begin
                    checkCount++;
                    $display("[TB] FAIL accept_timeout: ch%0d beat %h got no ready, required ready within 200 cycles", ch, d);
                end else begin
                    sbq.push_back('{ch, d, l});
                end
                @(posedge I_clk); #1;
            end
        end
        if (ch == 1) I_in1_valid = 1'b0;
        else         I_in2_valid = 1'b0;
    endtask

    task automatic drainAndCheckEmpty(input string name);
        repeat (3) @(negedge I_clk);
        checkCount++;
        if (sbq.size() !== 0)
            $display("[TB] FAIL %s_drain: got %0d beats outstanding, required 0", name, sbq.size());
        else
            passCount++;
    endtask

    task automatic test_reset();
        I_rst_n = 1'b0;
        repeat (2) @(posedge I_clk);
        #1;
        checkCount += 7;
        if (O_out_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b, required 0", O_out_valid); else passCount++;
        if (O_out_data !== 8'h00) $display("[TB] FAIL rst_data: got %h, required 00", O_out_data); else passCount++;
        if (O_out_last !== 1'b0) $display("[TB] FAIL rst_last: got %b, required 0", O_out_last); else passCount++;
        if (O_in1_ready !== 1'b0) $display("[TB] FAIL rst_ready1: got %b, required 0", O_in1_ready); else passCount++;
        if (O_in2_ready !== 1'b0) $display("[TB] FAIL rst_ready2: got %b, required 0", O_in2_ready); else passCount++;
        if (O_sel !== 1'b1) $display("[TB] FAIL rst_sel: got %b, required 1", O_sel); else passCount++;
        if (O_busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b, required 0", O_busy); else passCount++;
        I_rst_n = 1'b1;
        @(posedge I_clk); #1;
    endtask

    task automatic test_three_beats();
        pktStarts.delete();
        fork
            driveChannel(1, 1, 3, 8'h11);
            begin
                @(negedge I_clk);
                checkCount += 2;
                if (O_in1_ready !== 1'b0) $display("[TB] FAIL idle_ready1: got %b, required 0", O_in1_ready); else passCount++;
                if (O_busy !== 1'b0) $display("[TB] FAIL idle_busy: got %b, required 0", O_busy); else passCount++;
                @(negedge I_clk);
                checkCount += 3;
                if (O_busy !== 1'b1) $display("[TB] FAIL lock1_busy: got %b, required 1", O_busy); else passCount++;
                if (O_sel !== 1'b1) $display("[TB] FAIL lock1_sel: got %b, required 1", O_sel); else passCount++;
                if (O_in1_ready !== 1'b1) $display("[TB] FAIL lock1_ready1: got %b, required 1", O_in1_ready); else passCount++;
            end
        join
        @(negedge I_clk);
        checkCount += 2;
        if (O_busy !== 1'b0) $display("[TB] FAIL release_busy: got %b, required 0", O_busy); else passCount++;
        if (O_out_valid !== 1'b1) $display("[TB] FAIL last_latency: got valid %b, required 1", O_out_valid); else passCount++;
        @(negedge I_clk);
        checkCount++;
        if (O_out_valid !== 1'b0) $display("[TB] FAIL valid_clear: got %b, required 0", O_out_valid); else passCount++;
        drainAndCheckEmpty("three_beats");
    endtask

    task automatic test_alternate();
        int exp[6] = '{2, 1, 2, 1, 2, 1};
        pktStarts.delete();
        prevLastCyc = -1;
        gapCheck = 1;
        fork
            driveChannel(1, 3, 2, 8'h20);
            driveChannel(2, 3, 2, 8'h50);
        join
        drainAndCheckEmpty("alternate");
        gapCheck = 0;
        checkCount++;
        if (pktStarts.size() !== 6)
            $display("[TB] FAIL alt_count: got %0d packets, required 6", pktStarts.size());
        else begin
            passCount++;
            for (int i = 0; i < 6; i++) begin
                checkCount++;
                if (pktStarts[i] !== exp[i])
                    $display("[TB] FAIL alt_order[%0d]: got ch%0d, required ch%0d", i, pktStarts[i], exp[i]);
                else
                    passCount++;
            end
        end
    endtask

    task automatic test_backpressure();
        fork
            driveChannel(1, 1, 4, 8'h30);
            begin
                bit seen;
                seen = 0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge I_clk);
                    seen = O_out_valid;
                end
                @(posedge I_clk); #1;
                I_out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge I_clk);
                    checkCount += 3;
                    if (O_out_data !== 8'h31) $display("[TB] FAIL bp_hold_data: got %h, required 31", O_out_data); else passCount++;
                    if (O_out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid: got %b, required 1", O_out_valid); else passCount++;
                    if (O_in1_ready !== 1'b0) $display("[TB] FAIL bp_ready1: got %b, required 0", O_in1_ready); else passCount++;
                end
                @(posedge I_clk); #1;
                I_out_ready = 1'b1;
            end
        join
        drainAndCheckEmpty("backpressure");
    endtask

    task automatic test_single_in2();
        int exp[3] = '{2, 1, 2};
        pktStarts.delete();
        fork
            driveChannel(2, 1, 1, 8'hA5);
            begin
                bit seen;
                seen = 0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge I_clk);
                    seen = O_busy;
                end
                checkCount += 2;
                if (O_sel !== 1'b0) $display("[TB] FAIL lock2_sel: got %b, required 0", O_sel); else passCount++;
                if (O_in1_ready !== 1'b0) $display("[TB] FAIL lock2_ready1: got %b, required 0", O_in1_ready); else passCount++;
            end
        join
        drainAndCheckEmpty("single_in2");
        checkCount += 2;
        if (O_busy !== 1'b0) $display("[TB] FAIL single_busy: got %b, required 0", O_busy); else passCount++;
        if (O_sel !== 1'b0) $display("[TB] FAIL idle_sel_hold: got %b, required 0", O_sel); else passCount++;
        fork
            driveChannel(1, 1, 1, 8'h90);
            driveChannel(2, 1, 1, 8'hB0);
        join
        drainAndCheckEmpty("single_prio");
        for (int i = 0; i < 3; i++) begin
            checkCount++;
            if (i >= pktStarts.size())
                $display("[TB] FAIL single_order[%0d]: got no packet, required ch%0d", i, exp[i]);
            else if (pktStarts[i] !== exp[i])
                $display("[TB] FAIL single_order[%0d]: got ch%0d, required ch%0d", i, pktStarts[i], exp[i]);
            else
                passCount++;
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        int exp[2] = '{1, 2};
        I_in1_data = 8'h41; I_in1_valid = 1'b1; I_in1_last = 1'b0;
        got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge I_clk);
            got = O_in1_ready;
        end
        if (got) sbq.push_back('{1, 8'h41, 1'b0});
        @(posedge I_clk); #1;
        I_in1_data = 8'h42;
        @(negedge I_clk);
        #2;
        I_rst_n = 1'b0;
        #1;
        checkCount += 7;
        if (sbq.size() !== 0) $display("[TB] FAIL mid_first_beat: got %0d outstanding, required 0", sbq.size()); else passCount++;
        if (O_out_valid !== 1'b0) $display("[TB] FAIL mid_valid: got %b, required 0", O_out_valid); else passCount++;
        if (O_out_data !== 8'h00) $display("[TB] FAIL mid_data: got %h, required 00", O_out_data); else passCount++;
        if (O_in1_ready !== 1'b0) $display("[TB] FAIL mid_ready1: got %b, required 0", O_in1_ready); else passCount++;
        if (O_sel !== 1'b1) $display("[TB] FAIL mid_sel: got %b, required 1", O_sel); else passCount++;
        if (O_busy !== 1'b0) $display("[TB] FAIL mid_busy: got %b, required 0", O_busy); else passCount++;
        if (O_out_last !== 1'b0) $display("[TB] FAIL mid_last: got %b, required 0", O_out_last); else passCount++;
        sbq.delete();
        inPkt = 0;
        I_in1_valid = 1'b0;
        @(posedge I_clk); #1;
        I_rst_n = 1'b1;
        pktStarts.delete();
        fork
            driveChannel(1, 1, 1, 8'h70);
            driveChannel(2, 1, 2, 8'h60);
        join
        drainAndCheckEmpty("after_reset");
        for (int i = 0; i < 2; i++) begin
            checkCount++;
            if (i >= pktStarts.size())
                $display("[TB] FAIL post_rst_order[%0d]: got no packet, required ch%0d", i, exp[i]);
            else if (pktStarts[i] !== exp[i])
                $display("[TB] FAIL post_rst_order[%0d]: got ch%0d, required ch%0d", i, pktStarts[i], exp[i]);
            else
                passCount++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_three_beats();
        test_alternate();
        test_backpressure();
        test_single_in2();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mux2_stream_arb.md
MUX2_STREAM_ARB -- requirements
Module: mux2_stream_arb

Interface
REQ-001 Parameter: DATA_W, default 8, payload width of both input streams and the output.
REQ-002 Ports, clock and reset first:
- I_clk  input  1  sole clock; all state updates on its rising edge.
- I_rst_n  input  1  asynchronous, active-low reset.
- I_in1_data  input  DATA_W  channel-1 payload.
- I_in1_valid  input  1  channel-1 beat present.
- I_in1_last  input  1  channel-1 final beat of packet.
- O_in1_ready  output  1  channel-1 beat accepted when high with I_in1_valid.
- I_in2_data  input  DATA_W  channel-2 payload.
- I_in2_valid  input  1  channel-2 beat present.
- I_in2_last  input  1  channel-2 final beat of packet.
- O_in2_ready  output  1  channel-2 beat accepted when high with I_in2_valid.
- O_out_data  output  DATA_W  registered output payload.
- O_out_valid  output  1  output beat present.
- O_out_last  output  1  output final beat of packet.
- I_out_ready  input  1  downstream accepts the beat when high with O_out_valid.
- O_sel  output  1  registered grant: 1 = channel 1, 0 = channel 2; drives a downstream 2:1 select.
- O_busy  output  1  high while a packet is locked (LOCK1/LOCK2).

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, LOCK1, LOCK2.
REQ-004 In IDLE, the FSM SHALL move to LOCK1 if only I_in1_valid is high, or to LOCK2 if only I_in2_valid is high.
REQ-005 In IDLE with both valids high, the FSM SHALL enter the lock of the channel indicated by the priority pointer.
REQ-006 In IDLE, both readies SHALL be 0; the grant takes effect the cycle after the decision.
REQ-007 Ready generation:
- O_in1_ready = (state==LOCK1) && (!O_out_valid || I_out_ready).
- O_in2_ready is the same term with LOCK2.
- The ungranted channel's ready SHALL be 0 regardless of its valid.
REQ-008 An accepted beat SHALL be loaded into the output register, so it appears on O_out_data/O_out_last with O_out_valid=1 in the next cycle (latency 1).
REQ-009 O_out_valid SHALL clear on the cycle after acceptance when no new beat is loaded in the same cycle.
REQ-010 While O_out_valid=1 and I_out_ready=0, O_out_data and O_out_last SHALL hold stable.
REQ-011 Full throughput: with input valid and I_out_ready both held high in a lock state, one beat per cycle SHALL be transferred.
REQ-012 On acceptance of a beat with last=1 in LOCKx, the FSM SHALL return to IDLE, and the priority pointer SHALL point to the other channel.
- This costs exactly one bubble cycle between packets.
- A single-beat packet (valid and last on its first beat) SHALL be handled identically.
REQ-013 O_sel SHALL be 1 in LOCK1 and 0 in LOCK2, and SHALL hold its previous value in IDLE.
REQ-014 O_busy SHALL be 1 exactly in LOCK1/LOCK2.
REQ-015 A packet SHALL never be interleaved with the other channel; a lock is released only by its last beat, with no timeout.
REQ-016 Input valid dropping mid-packet SHALL stall the lock without releasing it.

Reset
REQ-017 While I_rst_n=0, asynchronously:
- state = IDLE; priority pointer = channel 1.
- O_out_valid = 0, O_out_data = 0, O_out_last = 0.
- O_in1_ready = 0, O_in2_ready = 0.
- O_sel = 1, O_busy = 0.
REQ-018 Reset asserted mid-packet SHALL discard the partial packet and any held output beat.
REQ-019 After reset release, arbitration SHALL restart from IDLE with channel-1 priority.

Structure
REQ-020 FSM state encodings (2 bits) and the DATA_W default SHALL live in the shared mux package/header.
REQ-021 The output register with valid/ready hold logic SHALL be a sub-module, mux_out_reg, parameterised by DATA_W plus a last bit.
REQ-022 The top level SHALL contain only the FSM, the priority pointer, and the ready/select logic.

Verification
REQ-023 Reset, then in1 sends 3 beats (0x11, 0x12, 0x13 with last) while I_out_ready=1 -> O_sel=1, outputs 0x11..0x13 on consecutive cycles one cycle after acceptance, O_out_last on 0x13, then IDLE.
REQ-024 Both valid continuously with 2-beat packets -> grants alternate in1, in2, in1, ..., with one bubble cycle between packets and no interleaving.
REQ-025 Backpressure: I_out_ready=0 for 4 cycles mid-packet -> O_out_data is stable, the granted ready is 0, and no beat is lost or duplicated.
REQ-026 A single-beat packet on in2 (0xA5, last) while in1 is idle -> LOCK2, O_sel=0, 0xA5 output with last, return to IDLE, pointer set to in1.
REQ-027 I_rst_n pulsed low during beat 2 of a 4-beat in1 packet -> all outputs return to reset values immediately, and after release an in2 request is granted normally.
